// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises whole packets from several requesters onto one UART.
// Frame on the wire: length, 0x00, 0x00, type, payload bytes (payload byte 0 first).
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_LEN = 16
) (
  input  logic                                sys_clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [8*NUM_REQ-1:0]                req_len,
  input  logic [8*NUM_REQ-1:0]                req_type,
  input  logic [8*(MAX_LEN-4)*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_REQ-1:0]                  done,
  output logic                                err,
  output logic                                busy,
  output logic                                transmit,
  output logic [7:0]                          tx_byte,
  input  logic                                is_transmitting
);
  localparam int P  = MAX_LEN - 4;
  localparam int PW = 8 * P;
  localparam int RW = $clog2(NUM_REQ);
  localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
  localparam logic [RW-1:0] LAST_RST = RW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       last_q, last_d, sel_q, sel_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  logic                err_q, err_d, transmit_q, transmit_d, bad_q, bad_d;
  logic [7:0]          tx_byte_q, tx_byte_d, idx_q, idx_d, len_q, len_d, type_q, type_d;
  logic [PW-1:0]       data_q, data_d;
  logic [2:0]          cnt_q, cnt_d;

  logic [7:0]          len_a  [NUM_REQ];
  logic [7:0]          type_a [NUM_REQ];
  logic [PW-1:0]       data_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign len_a[g]  = req_len[8*g +: 8];
    assign type_a[g] = req_type[8*g +: 8];
    assign data_a[g] = req_data[PW*g +: PW];
  end

  // Round-robin search starting just after the last winner.
  logic          found;
  logic [RW-1:0] win, cand;
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = RW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    done_d     = '0;
    err_d      = 1'b0;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    idx_d      = idx_q;
    len_d      = len_q;
    type_d     = type_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          last_d       = win;
          sel_d        = win;
          len_d        = len_a[win];
          type_d       = type_a[win];
          data_d       = data_a[win];
          idx_d        = 8'd0;
          // Bad lengths park in WAIT_LO for one cycle, then report done+err.
          if (len_a[win] < 8'd4 || len_a[win] > LEN_MAX) begin
            bad_d   = 1'b1;
            state_d = WAIT_LO;
          end else begin
            bad_d   = 1'b0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        transmit_d = 1'b1;
        case (idx_q)
          8'd0:       tx_byte_d = len_q;
          8'd1, 8'd2: tx_byte_d = 8'h00;
          8'd3:       tx_byte_d = type_q;
          default: begin
            tx_byte_d = data_q[PW-1 -: 8];
            data_d    = data_q << 8;
          end
        endcase
        idx_d   = idx_q + 8'd1;
        cnt_d   = 3'd0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        cnt_d = cnt_q + 3'd1;
        // Bounded wait so a UART that never raises its flag cannot hang us.
        if (is_transmitting || cnt_q == 3'd7) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (bad_q) begin
          done_d[sel_q] = 1'b1;
          err_d         = 1'b1;
          grant_d       = '0;
          bad_d         = 1'b0;
          state_d       = IDLE;
        end else if (!is_transmitting) begin
          if (idx_q == len_q) begin
            done_d[sel_q] = 1'b1;
            grant_d       = '0;
            state_d       = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= LAST_RST;
      sel_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      idx_q      <= 8'd0;
      len_q      <= 8'd0;
      type_q     <= 8'd0;
      data_q     <= '0;
      cnt_q      <= 3'd0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      type_q     <= type_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
    end
  end

  assign grant    = grant_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between several packet sources, such as the command parser's PONG/INFO/INVALID replies and mining-core result reports. Each requester presents a complete packet, and the block grants requesters round-robin. It serialises the granted packet in the standard framing: length, 0x00, 0x00, type, then payload. It drives the UART's `transmit`/`tx_byte` pair and paces itself on `is_transmitting`.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `MAX_LEN`, default 16: maximum total packet length in bytes, header included. The payload capacity is P = MAX_LEN-4.
- `sys_clk` input 1: single clock, the UART clock domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input NUM_REQ: per-requester packet request. Level; hold until `done[i]`.
- `req_len` input 8*NUM_REQ: total packet length in bytes for requester i, in slice [8i+:8].
- `req_type` input 8*NUM_REQ: message type byte, in slice [8i+:8].
- `req_data` input 8*P*NUM_REQ: payload for requester i, in slice [8Pi+:8P]. Payload byte 0 is the MSB byte of the slice.
- `grant` output NUM_REQ: one-hot; high for the whole packet of the granted requester.
- `done` output NUM_REQ: one-cycle pulse when requester i's packet is finished or rejected.
- `err` output 1: one-cycle pulse, coincident with `done`, when a packet is rejected.
- `busy` output 1: high in any state other than IDLE.
- `transmit` output 1: one-cycle pulse to the UART to send `tx_byte`.
- `tx_byte` output 8: byte sent to the UART.
- `is_transmitting` input 1: UART transmitter busy flag.

## Operation
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- **IDLE:** if any `req` bit is set, pick the winner round-robin.
  - The search starts at `last+1` modulo NUM_REQ.
  - The winner sets `grant`, and `last` is set to the winner.
  - `req_len`, `req_type` and `req_data` of the winner are captured into internal registers. Requester inputs are not used after this edge.
  - Set byte index `idx` = 0.
  - Go to SEND, except for invalid lengths as below.
- **Invalid length** (`req_len` < 4 or `req_len` > MAX_LEN):
  - No bytes are sent.
  - `grant` pulses for one cycle. On the next edge `done[i]` and `err` pulse, and the FSM returns to IDLE.
  - The round-robin pointer still advances.
- **SEND:** pulse `transmit` and drive `tx_byte` from `idx`:
  - idx 0: length.
  - idx 1 and 2: 0x00.
  - idx 3: type.
  - idx k ≥ 4: payload byte k-4.
  - Then `idx` increments and the FSM goes to WAIT_HI.
- **WAIT_HI:**
  - Go to WAIT_LO when `is_transmitting` = 1.
  - Timeout: go to WAIT_LO anyway after 8 cycles in this state, for robustness against a UART that never raises the flag.
- **WAIT_LO:** when `is_transmitting` = 0:
  - If `idx` equals the captured length, pulse `done[i]`, clear `grant`, and go to IDLE.
  - Otherwise go to SEND.
- A packet always completes once granted. Deasserting `req[i]` mid-packet is ignored.
- New requests arriving during a packet wait for IDLE and never preempt.
- Length 4 sends the header only.
- Payload bytes beyond the captured length are never sent.

## Timing
- Reset values:
  - `grant`=0, `done`=0, `err`=0, `busy`=0, `transmit`=0, `tx_byte`=0x00.
  - State is IDLE.
  - `last` = NUM_REQ-1, so requester 0 has priority first.
- Reset asserted mid-packet forces every output to its reset value immediately (asynchronous). A partially sent packet is abandoned. The byte already inside the UART is out of scope.
- `req[i]` is sampled at edge t. `grant[i]` is high after edge t. The first `transmit` pulse is high after edge t+1.
- `tx_byte` is valid in the same cycle as `transmit` and holds until the next SEND.
- Per byte the cost is 1 SEND cycle, plus ≥1 cycle in WAIT_HI, plus the UART busy time, plus 1 cycle to observe `is_transmitting` low.
- `done[i]` is high in the cycle after `is_transmitting` is observed low for the last byte. `grant` falls on the same edge.
- A request sampled in IDLE is granted on the next edge, so a held `req` gives back-to-back packets with one idle cycle between them.
- A simultaneous `done` and a new `req` from the same requester: the `req` is honoured, because `done` fires in WAIT_LO and not IDLE.
- `grant` never has more than one bit set. `transmit` never pulses while `is_transmitting` = 1.

## Test plan
- **Single valid packet:** req0, len=8, type=0x01, payload DE AD BE EF → UART bytes 08 00 00 01 DE AD BE EF, eight `transmit` pulses, one `done[0]`, `err`=0.
- **Fairness:** req0 and req1 raised in the same cycle and held for two packets each → grant order 0, 1, 0, 1, with no interleaving of bytes between packets.
- **Invalid lengths:** len=3, and separately len=17 with MAX_LEN=16 → zero `transmit` pulses, `done[i]` and `err` pulse together, then the FSM is back in IDLE.
- **Header-only packet:** len=4, type=0x00 → bytes 04 00 00 00.
- **Slow UART:** hold `is_transmitting` high for 200 cycles per byte → the next `transmit` only comes after the falling edge. Separately, never raise the flag → the WAIT_HI timeout lets the packet complete.
- **Reset mid-packet:** assert `rst_n`=0 after the third byte → all outputs go to 0 immediately. After release, req1 pending is granted first, since `last` is reset and requester 0 is idle.
